// File: rtl/cfs_md_rx_ctrl.sv
// MD slave-side receive stage: handshakes MD RX transfers, drops and counts illegal ones, queues legal ones for the aligner.
// Optional build macro CFS_MD_RX_ZERO_WAIT_EN replaces the two-cycle handshake with a combinational ready.
module cfs_md_rx_ctrl #(
  parameter int  DATA_WIDTH   = 32,
  parameter int  FIFO_DEPTH   = 4,
  localparam int BYTES        = DATA_WIDTH / 8,
  localparam int OFFSET_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1,
  localparam int SIZE_WIDTH   = $clog2(BYTES) + 1,
  localparam int LEVEL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    md_rx_valid,
  input  logic [DATA_WIDTH-1:0]   md_rx_data,
  input  logic [OFFSET_WIDTH-1:0] md_rx_offset,
  input  logic [SIZE_WIDTH-1:0]   md_rx_size,
  output logic                    md_rx_ready,
  output logic                    md_rx_err,
  output logic                    push_valid,
  output logic [DATA_WIDTH-1:0]   push_data,
  output logic [OFFSET_WIDTH-1:0] push_offset,
  output logic [SIZE_WIDTH-1:0]   push_size,
  input  logic                    push_ready,
  output logic [LEVEL_WIDTH-1:0]  fifo_level,
  output logic [15:0]             illegal_cnt
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] DEPTH_L = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [SIZE_WIDTH:0]    BYTES_L = (SIZE_WIDTH + 1)'(BYTES);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [SIZE_WIDTH-1:0]   size;
  } entry_t;

  entry_t                 mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [SIZE_WIDTH:0] span;
  logic                illegal, room, push, pop, count_illegal;

  // One extra bit so size + offset cannot wrap back into the legal range.
  assign span    = (SIZE_WIDTH + 1)'(md_rx_size) + (SIZE_WIDTH + 1)'(md_rx_offset);
  assign illegal = (md_rx_size == '0) || (span > BYTES_L);
  assign room    = (level_q < DEPTH_L);
  assign pop     = push_ready && (level_q != '0);

`ifdef CFS_MD_RX_ZERO_WAIT_EN
  assign md_rx_ready   = room || illegal;
  assign md_rx_err     = md_rx_valid && md_rx_ready && illegal;
  assign push          = md_rx_valid && md_rx_ready && !illegal;
  assign count_illegal = md_rx_valid && md_rx_ready && illegal;
`else
  typedef enum logic {IDLE, ACK} state_t;

  state_t state_q;
  logic   ready_q, err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md_rx_valid && (illegal || room)) begin
            state_q <= ACK;
            ready_q <= 1'b1;
            err_q   <= illegal;
          end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign md_rx_ready   = ready_q;
  assign md_rx_err     = err_q;
  // Legality was judged when ACK was entered; payload is taken from the bus during ACK.
  assign push          = ready_q && md_rx_valid && !err_q;
  assign count_illegal = ready_q && err_q;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
      2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
      default: level_d = level_q;
    endcase
    if (count_illegal && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: entry storage has no reset; push_valid gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: md_rx_data, offset: md_rx_offset, size: md_rx_size};
  end

  assign push_valid  = (level_q != '0);
  assign push_data   = mem_q[rd_ptr_q].data;
  assign push_offset = mem_q[rd_ptr_q].offset;
  assign push_size   = mem_q[rd_ptr_q].size;
  assign fifo_level  = level_q;
  assign illegal_cnt = cnt_q;

endmodule
